ps_mm_ring_ctrl: RTL

- Packet-granular ring-buffer controller placed in front of the PacketStream-to-Avalon-MM writer.
- Admits a packet only when the ring holds at least MAX_PKT_WORDS free words.
- Supplies the writer's start address for each packet, forwards the stream, counts words, truncates oversize packets and emits one descriptor (start address, length, last-word empty count, truncation flag) per packet.
- A downstream consumer returns ring space through a release interface.

---
 rtl/ps_mm_ring_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ps_mm_ring_ctrl.sv
// Packet-granular ring-buffer controller in front of a PacketStream-to-Avalon-MM writer.
// Optional statistics counters are enabled with `define PS_MM_RING_CTRL_STAT_EN.
module ps_mm_ring_ctrl #(
  parameter int DWIDTH        = 8,
  parameter int AWIDTH        = 8,
  parameter int SYMBOLS       = 4,
  parameter int MAX_PKT_WORDS = 16,
  localparam int MW           = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DWIDTH-1:0] i_dat,
  input  logic [MW-1:0]     i_mty,
  input  logic              i_val,
  input  logic              i_eop,
  output logic              i_rdy,
  output logic [DWIDTH-1:0] o_dat,
  output logic [MW-1:0]     o_mty,
  output logic              o_val,
  output logic              o_eop,
  input  logic              o_rdy,
  output logic [AWIDTH-1:0] o_address,
  output logic [AWIDTH-1:0] d_addr,
  output logic [AWIDTH:0]   d_len,
  output logic [MW-1:0]     d_mty,
  output logic              d_trunc,
  output logic              d_val,
  input  logic              d_rdy,
  input  logic [AWIDTH:0]   rel_words,
  input  logic              rel_val,
`ifdef PS_MM_RING_CTRL_STAT_EN
  input  logic              stat_clr,
  output logic [31:0]       stat_pkts,
  output logic [31:0]       stat_trunc,
`endif
  output logic [AWIDTH:0]   used
);

  localparam logic [AWIDTH:0] RING_W = (AWIDTH+1)'(2**AWIDTH);
  localparam logic [AWIDTH:0] MAX_W  = (AWIDTH+1)'(MAX_PKT_WORDS);

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  state_t              r_state, w_state_nxt;
  logic [AWIDTH-1:0]   r_wr_ptr;
  logic [AWIDTH:0]     r_used, r_cnt;
  logic [AWIDTH-1:0]   r_d_addr;
  logic [AWIDTH:0]     r_d_len;
  logic [MW-1:0]       r_d_mty;
  logic                r_d_trunc, r_d_val;

  logic [AWIDTH:0]     w_free, w_cnt_inc;
  logic                w_admit, w_beat, w_at_max, w_eop_beat, w_trunc_beat, w_desc_load;
  logic [AWIDTH+1:0]   w_used_sum, w_rel, w_used_diff;
  logic [AWIDTH:0]     w_used_nxt;

  assign w_free       = RING_W - r_used;
  assign w_admit      = (w_free >= MAX_W) && !r_d_val;
  assign w_beat       = (r_state == PASS) && i_val && o_rdy;
  assign w_cnt_inc    = r_cnt + 1'b1;
  assign w_at_max     = (w_cnt_inc == MAX_W);
  assign w_eop_beat   = w_beat && i_eop;
  assign w_trunc_beat = w_beat && !i_eop && w_at_max;
  assign w_desc_load  = w_eop_beat || w_trunc_beat;

  // A release larger than the current occupancy clamps to empty instead of wrapping.
  assign w_used_sum  = {1'b0, r_used} + (AWIDTH+2)'(w_beat);
  assign w_rel       = rel_val ? {1'b0, rel_words} : '0;
  assign w_used_diff = w_used_sum - w_rel;
  assign w_used_nxt  = (w_rel > w_used_sum) ? '0 : w_used_diff[AWIDTH:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (i_val && w_admit) w_state_nxt = PASS;
      PASS: if (w_eop_beat) w_state_nxt = IDLE;
            else if (w_trunc_beat) w_state_nxt = DROP;
      DROP: if (i_val && i_eop) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    i_rdy = 1'b0;
    o_val = 1'b0;
    o_dat = i_dat;
    o_mty = i_mty;
    o_eop = i_eop;
    unique case (r_state)
      PASS: begin
        o_val = i_val;
        i_rdy = o_rdy;
        if (w_at_max && !i_eop) begin
          o_eop = 1'b1;
          o_mty = '0;
        end
      end
      DROP:    i_rdy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr  <= '0;
      r_used    <= '0;
      r_cnt     <= '0;
      r_d_addr  <= '0;
      r_d_len   <= '0;
      r_d_mty   <= '0;
      r_d_trunc <= 1'b0;
      r_d_val   <= 1'b0;
    end else begin
      r_used <= w_used_nxt;
      if (w_desc_load)  r_cnt <= '0;
      else if (w_beat)  r_cnt <= w_cnt_inc;
      // Admission is blocked while a descriptor is pending, so load and clear never coincide.
      if (w_desc_load) begin
        r_wr_ptr  <= r_wr_ptr + w_cnt_inc[AWIDTH-1:0];
        r_d_addr  <= r_wr_ptr;
        r_d_len   <= w_cnt_inc;
        r_d_mty   <= w_eop_beat ? i_mty : '0;
        r_d_trunc <= w_trunc_beat;
        r_d_val   <= 1'b1;
      end else if (r_d_val && d_rdy) begin
        r_d_val   <= 1'b0;
      end
    end
  end

`ifdef PS_MM_RING_CTRL_STAT_EN
  logic [31:0] r_stat_pkts, r_stat_trunc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_pkts  <= '0;
      r_stat_trunc <= '0;
    end else if (stat_clr) begin
      r_stat_pkts  <= '0;
      r_stat_trunc <= '0;
    end else begin
      if (w_desc_load)  r_stat_pkts  <= r_stat_pkts + 32'd1;
      if (w_trunc_beat) r_stat_trunc <= r_stat_trunc + 32'd1;
    end
  end

  assign stat_pkts  = r_stat_pkts;
  assign stat_trunc = r_stat_trunc;
`endif

  assign o_address = r_wr_ptr;
  assign used      = r_used;
  assign d_addr    = r_d_addr;
  assign d_len     = r_d_len;
  assign d_mty     = r_d_mty;
  assign d_trunc   = r_d_trunc;
  assign d_val     = r_d_val;

endmodule
